// File: rtl/diff_in_receiver.sv
// Differential pad receiver: synchronizes diff_p/diff_n, glitch-filters the level, flags p==n, pulses on edges.
// Build option: define DIFF_RX_IBUFDS_EN to take the pads through an IBUFDS into a single sync chain.
module diff_in_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int INVALID_LEN = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             diff_p,
    input  logic             diff_n,
    input  logic             clr_count,
    output logic             data,
    output logic             rise,
    output logic             fall,
    output logic             invalid,
    output logic [CNT_W-1:0] edge_count
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int INV_W  = $clog2(INVALID_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [INV_W-1:0]  INV_MAX   = INV_W'(INVALID_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              sp;
    logic              valid;
    logic              toggle;
    logic [FILT_W-1:0] filt_cnt;
    logic [INV_W-1:0]  inv_cnt;

`ifdef DIFF_RX_IBUFDS_EN
    logic                   pad_se;
    logic [SYNC_STAGES-1:0] sync_se;

    IBUFDS u_ibufds (
        .I  (diff_p),
        .IB (diff_n),
        .O  (pad_se)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_se <= '0;
        else        sync_se <= {sync_se[SYNC_STAGES-2:0], pad_se};
    end

    assign sp    = sync_se[SYNC_STAGES-1];
    assign valid = 1'b1;
`else
    logic [SYNC_STAGES-1:0] sync_p;
    logic [SYNC_STAGES-1:0] sync_n;

    // Legs reset to the idle "logic 0" pair (p=0, n=1) so release never looks like p==n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
            sync_n <= '1;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], diff_p};
            sync_n <= {sync_n[SYNC_STAGES-2:0], diff_n};
        end
    end

    assign sp    = sync_p[SYNC_STAGES-1];
    assign valid = sync_p[SYNC_STAGES-1] ^ sync_n[SYNC_STAGES-1];
`endif

    assign toggle = valid && (sp != data) && (filt_cnt == FILT_LAST);

    // Illegal samples freeze the filter rather than resetting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            data     <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (valid) begin
                if (sp == data) begin
                    filt_cnt <= '0;
                end else if (toggle) begin
                    filt_cnt <= '0;
                    data     <= sp;
                    rise     <= sp;
                    fall     <= ~sp;
                end else begin
                    filt_cnt <= filt_cnt + FILT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_cnt <= '0;
            invalid <= 1'b0;
        end else if (valid) begin
            inv_cnt <= '0;
            invalid <= 1'b0;
        end else begin
            if (inv_cnt != INV_MAX) inv_cnt <= inv_cnt + INV_W'(1);
            invalid <= (inv_cnt >= INV_MAX - INV_W'(1));
        end
    end

    // Counted on the same edge the pulse is launched, so a clear sampled there wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             edge_count <= '0;
        else if (clr_count)                     edge_count <= '0;
        else if (toggle && edge_count != CNT_MAX) edge_count <= edge_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_diff_in_receiver.sv
// Bench for diff_in_receiver: sample-history model checked every cycle plus directed literal checks.
module tb_diff_in_receiver;

    localparam int SYNC = 2;
    localparam int FLEN = 3;
    localparam int ILEN = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          diff_p    = 1'b1;
    logic          diff_n    = 1'b0;
    logic          clr_count = 1'b0;
    logic          data;
    logic          rise;
    logic          fall;
    logic          invalid;
    logic [CW-1:0] edge_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    diff_in_receiver #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FLEN),
        .INVALID_LEN (ILEN),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .diff_p     (diff_p),
        .diff_n     (diff_n),
        .clr_count  (clr_count),
        .data       (data),
        .rise       (rise),
        .fall       (fall),
        .invalid    (invalid),
        .edge_count (edge_count)
    );

    task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Model: the filter sees the pad pair as it was SYNC edges ago; a level change needs
    // FLEN differing legal samples with no agreeing legal sample between them.
    logic [1:0] hist [SYNC] = '{default: 2'b01};
    logic [1:0] smp;
    bit         run_q [$];
    int         inv_run = 0;
    int         m_cnt   = 0;
    logic       m_data  = 1'b0;
    logic       m_rise  = 1'b0;
    logic       m_fall  = 1'b0;
    logic       m_inv   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 2'b01;
            run_q.delete();
            inv_run = 0;
            m_cnt   = 0;
            m_data  = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_inv   = 1'b0;
        end else begin
            smp = hist[SYNC-1];
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {diff_p, diff_n};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (smp[1] != smp[0]) begin
                inv_run = 0;
                if (smp[1] == m_data) begin
                    run_q.delete();
                end else begin
                    run_q.push_back(smp[1]);
                    if (run_q.size() == FLEN) begin
                        m_data = smp[1];
                        m_rise = smp[1];
                        m_fall = ~smp[1];
                        run_q.delete();
                    end
                end
            end else if (inv_run < ILEN) begin
                inv_run++;
            end
            m_inv = (inv_run >= ILEN);
            if (clr_count) m_cnt = 0;
            else if ((m_rise || m_fall) && m_cnt < CMAX) m_cnt++;
        end
    end

    always @(negedge clk) begin
        chkv("cycle", 32'({data, rise, fall, invalid, edge_count}),
             32'({m_data, m_rise, m_fall, m_inv, m_cnt[CW-1:0]}));
    end

    task automatic pad(input logic p, input logic n);
        diff_p = p;
        diff_n = n;
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        // 1: reset with pad already high, then release
        rst_n = 1'b0;
        pad(1'b1, 1'b0);
        step(3);
        chkv("rst_outputs", 32'({data, rise, fall, invalid, edge_count}), 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk1("t1_rise", rise, k == 5);
            chk1("t1_data", data, k >= 5);
        end
        chkv("t1_count", 32'(edge_count), 32'd1);

        // 2: return to 0, then a 2-cycle glitch
        pad(1'b0, 1'b1);
        step(10);
        chk1("t2_pre_data", data, 1'b0);
        pad(1'b1, 1'b0);
        step(2);
        pad(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk1("t2_no_rise", rise, 1'b0);
        end
        chk1("t2_data", data, 1'b0);
        chkv("t2_count", 32'(edge_count), 32'd2);

        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        chkv("clr_count", 32'(edge_count), 32'd0);

        // 3: four toggles, 10 cycles apart
        for (int c = 0; c < 4; c++) begin
            pad((c % 2) == 0, (c % 2) != 0);
            for (int k = 1; k <= 10; k++) begin
                step(1);
                chk1("t3_rise", rise, ((c % 2) == 0) && (k == 5));
                chk1("t3_fall", fall, ((c % 2) != 0) && (k == 5));
            end
        end
        chkv("t3_count", 32'(edge_count), 32'd4);

        // 4: illegal p==n while data=1
        pad(1'b1, 1'b0);
        step(10);
        chk1("t4_pre_data", data, 1'b1);
        pad(1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk1("t4_invalid", invalid, k >= 6);
            chk1("t4_hold", data, 1'b1);
        end
        pad(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk1("t4_inv_clear", invalid, k <= 2);
            chk1("t4_fall", fall, k == 5);
            chk1("t4_data", data, k < 5);
        end

        // 5: saturate the counter, then clear on the pulse edge
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        for (int i = 0; i < 260; i++) begin
            pad((i % 2) == 0, (i % 2) != 0);
            step(5);
        end
        chkv("t5_saturate", 32'(edge_count), 32'(CMAX));
        pad(1'b1, 1'b0);
        step(4);
        clr_count = 1'b1;
        step(1);
        clr_count = 1'b0;
        chk1("t5_pulse", rise, 1'b1);
        chkv("t5_clear", 32'(edge_count), 32'd0);

        // 6: async reset two edges into a pending fall
        pad(1'b0, 1'b1);
        step(3);
        #2 rst_n = 1'b0;
        #1 chkv("t6_async", 32'({data, rise, fall, invalid, edge_count}), 32'd0);
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk1("t6_no_rise", rise, 1'b0);
            chk1("t6_no_fall", fall, 1'b0);
        end
        pad(1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk1("t6_reacquire", rise, k == 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
